gate_truth_checker: RTL and testbench

//   Sequential stimulus/response stage wrapped around a 2-input combinational gate (default: NAND).

---
 rtl/gate_truth_checker.sv | 117 +++++++++++
 tb/tb_gate_truth_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - sweeps a 2-input gate through all vectors and checks y against a truth table
module gate_truth_checker #(
    parameter int         SETTLE_CYCLES = 2,
    parameter int         PASSES        = 1,
    parameter logic [3:0] EXPECT_TT     = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       first_err_valid,
    output logic [1:0] first_err_vec
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // Terminal counts; guarded so a zero-cycle settle never underflows.
    localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [7:0] PASS_LAST   = 8'((PASSES > 0) ? PASSES - 1 : 0);

    state_t     state;
    logic [1:0] vector;
    logic [7:0] pass_cnt;
    logic [7:0] settle_cnt;
    logic       mismatch;

    // Observed response against the expected table entry for the vector now on a/b.
    assign mismatch = (y != EXPECT_TT[vector]);

    // Sweep sequencer with registered outputs; a/b keep the last driven vector outside DRIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            a               <= 1'b0;
            b               <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 8'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 2'd0;
            vector          <= 2'd0;
            pass_cnt        <= 8'd0;
            settle_cnt      <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= DRIVE;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_count       <= 8'd0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= 2'd0;
                        vector          <= 2'd0;
                        pass_cnt        <= 8'd0;
                    end
                end
                DRIVE: begin
                    a          <= vector[1];
                    b          <= vector[0];
                    settle_cnt <= 8'd0;
                    state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != 8'd255) begin
                            err_count <= err_count + 8'd1;
                        end
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vector;
                        end
                    end
                    if (vector != 2'd3) begin
                        vector <= vector + 2'd1;
                        state  <= DRIVE;
                    end else if (pass_cnt != PASS_LAST) begin
                        vector   <= 2'd0;
                        pass_cnt <= pass_cnt + 8'd1;
                        state    <= DRIVE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == 8'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - directed-vector bench for gate_truth_checker
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_v [4];
    logic       a_v     [4];
    logic       b_v     [4];
    logic       y_v     [4];
    logic       busy_v  [4];
    logic       done_v  [4];
    logic       pass_v  [4];
    logic [7:0] err_v   [4];
    logic       fev_v   [4];
    logic [1:0] fe_v    [4];
    int         mode;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    // Gate models: instance 0 selectable, 1 and 3 AND (all mismatch), 2 correct NAND.
    assign y_v[0] = (mode == 0) ? ~(a_v[0] & b_v[0]) : (mode == 1) ? 1'b1 : (a_v[0] & b_v[0]);
    assign y_v[1] = a_v[1] & b_v[1];
    assign y_v[2] = ~(a_v[2] & b_v[2]);
    assign y_v[3] = a_v[3] & b_v[3];

    gate_truth_checker u_def (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .y(y_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
        .first_err_valid(fev_v[0]), .first_err_vec(fe_v[0])
    );

    gate_truth_checker #(.PASSES(3)) u_p3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .y(y_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
        .first_err_valid(fev_v[1]), .first_err_vec(fe_v[1])
    );

    gate_truth_checker #(.SETTLE_CYCLES(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .y(y_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
        .first_err_valid(fev_v[2]), .first_err_vec(fe_v[2])
    );

    gate_truth_checker #(.PASSES(255)) u_sat (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]), .y(y_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err_v[3]),
        .first_err_valid(fev_v[3]), .first_err_vec(fe_v[3])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns 1 time unit after the accepting edge.
    task automatic kick(input int idx);
        start_v[idx] = 1'b1;
        step();
        start_v[idx] = 1'b0;
    endtask

    // Edges counted from the accepting edge until done is seen; -1 if the budget runs out.
    task automatic wait_done(input int idx, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (done_v[idx] === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], fev_v[0], fe_v[0]} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags: got %0h expected 0",
                     {a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], fev_v[0], fe_v[0]});
        end
        n_cmp++;
        if (err_v[0] !== 8'd0) begin n_bad++; $display("FAIL reset_err: got %0d expected 0", err_v[0]); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_nand_sweep();
        logic [1:0] seen [4];
        int n;
        mode = 0;
        kick(0);
        n_cmp++;
        if (busy_v[0] !== 1'b1) begin n_bad++; $display("FAIL nand_busy: got %0b expected 1", busy_v[0]); end
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 1) seen[0] = {a_v[0], b_v[0]};
            if (i == 4) begin
                n_cmp++;
                if ({a_v[0], b_v[0]} !== 2'b00) begin n_bad++; $display("FAIL nand_hold: got %0b expected 00", {a_v[0], b_v[0]}); end
            end
            if (i == 5) seen[1] = {a_v[0], b_v[0]};
            if (i == 9) seen[2] = {a_v[0], b_v[0]};
            if (i == 13) seen[3] = {a_v[0], b_v[0]};
            if (done_v[0] === 1'b1) begin n = i; break; end
        end
        for (int v = 0; v < 4; v++) begin
            n_cmp++;
            if (seen[v] !== 2'(v)) begin n_bad++; $display("FAIL nand_vec%0d: got %0b expected %0b", v, seen[v], 2'(v)); end
        end
        n_cmp++;
        if (n != 17) begin n_bad++; $display("FAIL nand_latency: got %0d expected 17", n); end
        n_cmp++;
        if ({pass_v[0], fev_v[0], busy_v[0]} !== 3'b100) begin
            n_bad++; $display("FAIL nand_result: got %0b expected 100", {pass_v[0], fev_v[0], busy_v[0]});
        end
        n_cmp++;
        if (err_v[0] !== 8'd0) begin n_bad++; $display("FAIL nand_err: got %0d expected 0", err_v[0]); end
        step();
        n_cmp++;
        if (done_v[0] !== 1'b0) begin n_bad++; $display("FAIL nand_done_pulse: got %0b expected 0", done_v[0]); end
    endtask

    task automatic test_stuck_at_one();
        int n;
        mode = 1;
        kick(0);
        n_cmp++;
        if (pass_v[0] !== 1'b0) begin n_bad++; $display("FAIL stuck_pass_cleared: got %0b expected 0", pass_v[0]); end
        wait_done(0, 30, n);
        n_cmp++;
        if (n != 17) begin n_bad++; $display("FAIL stuck_latency: got %0d expected 17", n); end
        n_cmp++;
        if (err_v[0] !== 8'd1) begin n_bad++; $display("FAIL stuck_err: got %0d expected 1", err_v[0]); end
        n_cmp++;
        if ({pass_v[0], fev_v[0], fe_v[0]} !== 4'b0111) begin
            n_bad++; $display("FAIL stuck_first: got %0b expected 0111", {pass_v[0], fev_v[0], fe_v[0]});
        end
        mode = 0;
        step();
    endtask

    task automatic test_and_passes3();
        int n;
        kick(1);
        wait_done(1, 80, n);
        n_cmp++;
        if (n != 49) begin n_bad++; $display("FAIL p3_latency: got %0d expected 49", n); end
        n_cmp++;
        if (err_v[1] !== 8'd12) begin n_bad++; $display("FAIL p3_err: got %0d expected 12", err_v[1]); end
        n_cmp++;
        if ({pass_v[1], fev_v[1], fe_v[1]} !== 4'b0100) begin
            n_bad++; $display("FAIL p3_first: got %0b expected 0100", {pass_v[1], fev_v[1], fe_v[1]});
        end
        step();
    endtask

    task automatic test_zero_settle();
        int n;
        kick(2);
        wait_done(2, 30, n);
        n_cmp++;
        if (n != 9) begin n_bad++; $display("FAIL s0_latency: got %0d expected 9", n); end
        n_cmp++;
        if ({pass_v[2], err_v[2]} !== 9'h100) begin
            n_bad++; $display("FAIL s0_result: got %0h expected 100", {pass_v[2], err_v[2]});
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int n;
        int stray;
        mode = 0;
        kick(0);
        for (int i = 1; i <= 9; i++) step();
        n_cmp++;
        if ({a_v[0], b_v[0]} !== 2'b10) begin n_bad++; $display("FAIL rmid_vec: got %0b expected 10", {a_v[0], b_v[0]}); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], fev_v[0], fe_v[0], err_v[0]} !== 16'h0000) begin
            n_bad++;
            $display("FAIL rmid_cleared: got %0h expected 0",
                     {a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], fev_v[0], fe_v[0], err_v[0]});
        end
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d active cycles expected 0", stray); end
        kick(0);
        wait_done(0, 30, n);
        n_cmp++;
        if (n != 17) begin n_bad++; $display("FAIL rmid_rerun_latency: got %0d expected 17", n); end
        n_cmp++;
        if ({pass_v[0], err_v[0]} !== 9'h100) begin
            n_bad++; $display("FAIL rmid_rerun_result: got %0h expected 100", {pass_v[0], err_v[0]});
        end
        step();
    endtask

    task automatic test_start_held();
        int dones;
        int n;
        mode = 0;
        dones = 0;
        start_v[0] = 1'b1;
        step();
        for (int i = 1; i <= 17; i++) begin
            step();
            if (done_v[0] === 1'b1) dones++;
            if (i == 16) begin
                n_cmp++;
                if (busy_v[0] !== 1'b1) begin n_bad++; $display("FAIL held_busy: got %0b expected 1", busy_v[0]); end
            end
        end
        n_cmp++;
        if (dones != 1 || done_v[0] !== 1'b1) begin
            n_bad++; $display("FAIL held_one_done: got %0d pulses expected 1 at edge 17", dones);
        end
        n_cmp++;
        if (busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL held_done_ignored: got busy %0b expected 0", busy_v[0]); end
        step();
        start_v[0] = 1'b0;
        n_cmp++;
        if ({busy_v[0], done_v[0]} !== 2'b10) begin
            n_bad++; $display("FAIL held_reaccept: got %0b expected 10", {busy_v[0], done_v[0]});
        end
        wait_done(0, 30, n);
        n_cmp++;
        if (n != 17) begin n_bad++; $display("FAIL held_second_latency: got %0d expected 17", n); end
        step();
    endtask

    task automatic test_saturation();
        int n;
        kick(3);
        wait_done(3, 4200, n);
        n_cmp++;
        if (n != 4081) begin n_bad++; $display("FAIL sat_latency: got %0d expected 4081", n); end
        n_cmp++;
        if (err_v[3] !== 8'd255) begin n_bad++; $display("FAIL sat_err: got %0d expected 255", err_v[3]); end
        n_cmp++;
        if ({pass_v[3], fev_v[3], fe_v[3]} !== 4'b0100) begin
            n_bad++; $display("FAIL sat_first: got %0b expected 0100", {pass_v[3], fev_v[3], fe_v[3]});
        end
    endtask

    initial begin
        mode = 0;
        rst  = 1'b1;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        #1;
        test_reset();
        test_nand_sweep();
        test_stuck_at_one();
        test_and_passes3();
        test_zero_settle();
        test_reset_mid_run();
        test_start_held();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
